// File: rtl/time_set_pkg.sv
// Shared key codes, edit states and field wrap helpers for the front-panel clock setter.
package time_set_pkg;

    localparam logic [7:0] KEY_NONE = 8'h00;
    localparam logic [7:0] KEY_MODE = 8'h07;
    localparam logic [7:0] KEY_UP   = 8'h0B;
    localparam logic [7:0] KEY_DOWN = 8'h0D;
    localparam logic [7:0] KEY_SET  = 8'h0E;

    localparam logic [4:0] HOUR_MAX    = 5'd23;
    localparam logic [5:0] MIN_SEC_MAX = 6'd59;

    // Encoding doubles as the edit_field output value.
    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_EDIT_HOUR = 2'd1,
        ST_EDIT_MIN  = 2'd2,
        ST_EDIT_SEC  = 2'd3
    } state_t;

    function automatic logic [7:0] decode_key(input logic [7:0] raw);
        case (raw)
            KEY_MODE, KEY_UP, KEY_DOWN, KEY_SET: return raw;
            default:                             return KEY_NONE;
        endcase
    endfunction

    function automatic logic [4:0] wrap_hour(input logic [4:0] v, input logic up);
        if (up) return (v == HOUR_MAX) ? 5'd0 : v + 5'd1;
        return (v == 5'd0) ? HOUR_MAX : v - 5'd1;
    endfunction

    function automatic logic [5:0] wrap_ms(input logic [5:0] v, input logic up);
        if (up) return (v == MIN_SEC_MAX) ? 6'd0 : v + 6'd1;
        return (v == 6'd0) ? MIN_SEC_MAX : v - 6'd1;
    endfunction

endpackage

// File: rtl/key_repeat.sv
// Key decode, press edge detect and UP/DOWN auto-repeat; events are registered one-cycle pulses.
module key_repeat
    import time_set_pkg::*;
#(
    parameter int HOLD_CYC   = 6_000_000,
    parameter int REPEAT_CYC = 1_200_000
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] key_data,
    output logic       ev_mode,
    output logic       ev_up,
    output logic       ev_down,
    output logic       ev_set
);

    localparam int CMAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] HOLD_TC = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] REP_TC  = CW'(REPEAT_CYC - 1);

    logic [7:0]    code;
    logic [7:0]    key_prev;
    logic [CW-1:0] hold_cnt;
    logic          repeating;
    logic          press;
    logic          rpt_key;
    logic          rpt_fire;

    assign code     = decode_key(key_data);
    assign press    = (code != key_prev) && (code != KEY_NONE);
    assign rpt_key  = (code == key_prev) && ((code == KEY_UP) || (code == KEY_DOWN));
    // One counter serves both the initial hold delay and the repeat interval.
    assign rpt_fire = rpt_key && (hold_cnt == (repeating ? REP_TC : HOLD_TC));

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            key_prev  <= KEY_NONE;
            hold_cnt  <= '0;
            repeating <= 1'b0;
            ev_mode   <= 1'b0;
            ev_up     <= 1'b0;
            ev_down   <= 1'b0;
            ev_set    <= 1'b0;
        end else begin
            key_prev <= code;
            if (!rpt_key) begin
                hold_cnt  <= '0;
                repeating <= 1'b0;
            end else if (rpt_fire) begin
                hold_cnt  <= '0;
                repeating <= 1'b1;
            end else begin
                hold_cnt <= hold_cnt + CW'(1);
            end
            ev_mode <= press && (code == KEY_MODE);
            ev_set  <= press && (code == KEY_SET);
            ev_up   <= (press || rpt_fire) && (code == KEY_UP);
            ev_down <= (press || rpt_fire) && (code == KEY_DOWN);
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Time-of-day keeper with key-driven edit FSM, second prescaler and edit-field blink.
module time_set_ctrl
    import time_set_pkg::*;
#(
    parameter int CLK_FREQ   = 12_000_000,
    parameter int HOLD_CYC   = 6_000_000,
    parameter int REPEAT_CYC = 1_200_000,
    parameter int BLINK_CYC  = 3_000_000
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] key_data,
    output logic [4:0] hour,
    output logic [5:0] minute,
    output logic [5:0] second,
    output logic [1:0] edit_field,
    output logic       blink,
    output logic       sec_pulse
);

    localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
    localparam logic [PW-1:0] PRE_TC   = PW'(CLK_FREQ - 1);
    localparam logic [BW-1:0] BLINK_TC = BW'(BLINK_CYC - 1);

    state_t        state, state_n;
    logic          ev_mode, ev_up, ev_down, ev_set, any_ev;
    logic [PW-1:0] presc;
    logic [BW-1:0] blink_cnt;
    logic          tick;

    key_repeat #(
        .HOLD_CYC   (HOLD_CYC),
        .REPEAT_CYC (REPEAT_CYC)
    ) u_key_repeat (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .key_data (key_data),
        .ev_mode  (ev_mode),
        .ev_up    (ev_up),
        .ev_down  (ev_down),
        .ev_set   (ev_set)
    );

    assign any_ev     = ev_mode | ev_up | ev_down | ev_set;
    assign edit_field = state;
    // A SET arriving on the terminal cycle leaves RUN instead of ticking.
    assign tick       = (state == ST_RUN) && !ev_set && (presc == PRE_TC);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= ST_RUN;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_RUN:       if (ev_set) state_n = ST_EDIT_HOUR;
            ST_EDIT_HOUR: if (ev_set) state_n = ST_RUN; else if (ev_mode) state_n = ST_EDIT_MIN;
            ST_EDIT_MIN:  if (ev_set) state_n = ST_RUN; else if (ev_mode) state_n = ST_EDIT_SEC;
            ST_EDIT_SEC:  if (ev_set) state_n = ST_RUN; else if (ev_mode) state_n = ST_EDIT_HOUR;
            default:      state_n = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            hour      <= '0;
            minute    <= '0;
            second    <= '0;
            sec_pulse <= 1'b0;
            presc     <= '0;
        end else begin
            sec_pulse <= tick;
            if (state != ST_RUN || ev_set || tick) presc <= '0;
            else                                   presc <= presc + PW'(1);
            if (tick) begin
                second <= wrap_ms(second, 1'b1);
                if (second == MIN_SEC_MAX) begin
                    minute <= wrap_ms(minute, 1'b1);
                    if (minute == MIN_SEC_MAX) hour <= wrap_hour(hour, 1'b1);
                end
            end else if (ev_up || ev_down) begin
                case (state)
                    ST_EDIT_HOUR: hour   <= wrap_hour(hour, ev_up);
                    ST_EDIT_MIN:  minute <= wrap_ms(minute, ev_up);
                    ST_EDIT_SEC:  second <= wrap_ms(second, ev_up);
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            blink     <= 1'b1;
            blink_cnt <= '0;
        end else if (state_n == ST_RUN || any_ev) begin
            blink     <= 1'b1;
            blink_cnt <= '0;
        end else if (blink_cnt == BLINK_TC) begin
            blink     <= ~blink;
            blink_cnt <= '0;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with a seconds-of-day behavioural model checked every cycle.
module tb_time_set_ctrl;
    import time_set_pkg::*;

    localparam int CF = 10;
    localparam int HC = 20;
    localparam int RC = 5;
    localparam int BC = 4;

    logic       clk_in   = 1'b0;
    logic       rst_in   = 1'b1;
    logic [7:0] key_data = 8'h00;
    logic [4:0] hour;
    logic [5:0] minute, second;
    logic [1:0] edit_field;
    logic       blink, sec_pulse;

    int n_cmp = 0;
    int n_bad = 0;
    int pulse_cnt = 0;

    // Model state: time as seconds of day, edit field number, pending event.
    int         m_t, m_field, m_run, m_since, m_held;
    logic       m_blink, m_pulse;
    logic [7:0] m_ev, m_prev;

    time_set_ctrl #(
        .CLK_FREQ   (CF),
        .HOLD_CYC   (HC),
        .REPEAT_CYC (RC),
        .BLINK_CYC  (BC)
    ) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .key_data   (key_data),
        .hour       (hour),
        .minute     (minute),
        .second     (second),
        .edit_field (edit_field),
        .blink      (blink),
        .sec_pulse  (sec_pulse)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_decode(input logic [7:0] k);
        if (k == 8'h07 || k == 8'h0B || k == 8'h0D || k == 8'h0E) return k;
        return 8'h00;
    endfunction

    task automatic m_adjust(input int d);
        int h, mi, s;
        h  = m_t / 3600;
        mi = (m_t / 60) % 60;
        s  = m_t % 60;
        if (m_field == 1) h  = (h + 24 + d) % 24;
        if (m_field == 2) mi = (mi + 60 + d) % 60;
        if (m_field == 3) s  = (s + 60 + d) % 60;
        m_t = h * 3600 + mi * 60 + s;
    endtask

    task automatic model_reset();
        m_t = 0; m_field = 0; m_run = 0; m_since = 0; m_held = 0;
        m_blink = 1'b1; m_pulse = 1'b0; m_ev = 8'h00; m_prev = 8'h00;
    endtask

    task automatic model_step();
        logic [7:0] c;
        if (rst_in) begin
            model_reset();
            return;
        end
        m_pulse = 1'b0;
        if (m_field == 0) begin
            m_blink = 1'b1;
            if (m_ev == 8'h0E) begin
                m_field = 1; m_run = 0; m_since = 0;
            end else begin
                m_run++;
                if (m_run == CF) begin
                    m_run = 0; m_t = (m_t + 1) % 86400; m_pulse = 1'b1;
                end
            end
        end else begin
            m_run = 0;
            if (m_ev != 8'h00) begin
                m_since = 0;
                if (m_ev == 8'h0E)      m_field = 0;
                else if (m_ev == 8'h07) m_field = (m_field == 3) ? 1 : m_field + 1;
                else if (m_ev == 8'h0B) m_adjust(1);
                else                    m_adjust(-1);
            end else begin
                m_since++;
            end
            m_blink = (m_field == 0) ? 1'b1 : (((m_since / BC) % 2) == 0);
        end
        c = m_decode(key_data);
        m_ev = 8'h00;
        if (c != m_prev) begin
            m_held = 0;
            m_ev = c;
        end else begin
            m_held++;
            if ((c == 8'h0B || c == 8'h0D) &&
                (m_held == HC || (m_held > HC && ((m_held - HC) % RC) == 0)))
                m_ev = c;
        end
        m_prev = c;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk_in or posedge rst_in);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk_in);
            check("hour",       hour,       m_t / 3600);
            check("minute",     minute,     (m_t / 60) % 60);
            check("second",     second,     m_t % 60);
            check("edit_field", edit_field, m_field);
            check("blink",      blink,      m_blink);
            check("sec_pulse",  sec_pulse,  m_pulse);
            if (sec_pulse) pulse_cnt++;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_in);
        #1;
    endtask

    task automatic press(input logic [7:0] code);
        key_data = code;
        cycles(1);
        key_data = 8'h00;
        cycles(1);
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        cycles(2);
        rst_in = 1'b0;
    endtask

    task automatic check_time(input string name, input int h, input int mi, input int s);
        check({name, "_h"}, hour, h);
        check({name, "_m"}, minute, mi);
        check({name, "_s"}, second, s);
        check({name, "_model"}, m_t, h * 3600 + mi * 60 + s);
    endtask

    initial begin
        cycles(2);
        check_time("reset", 0, 0, 0);
        check("reset_field", edit_field, 0);
        check("reset_blink", blink, 1);
        check("reset_pulse", sec_pulse, 0);
        rst_in = 1'b0;

        pulse_cnt = 0;
        cycles(30);
        check("idle_pulses", pulse_cnt, 3);
        check_time("idle", 0, 0, 3);

        do_reset();
        press(KEY_SET); press(KEY_MODE); press(KEY_MODE); press(KEY_DOWN);
        check("sec_wrap_down", second, 59);
        check("sec_field", edit_field, 3);
        press(KEY_SET);
        check_time("preload59", 0, 0, 59);
        pulse_cnt = 0;
        cycles(10);
        check_time("min_carry", 0, 1, 0);
        check("min_carry_pulses", pulse_cnt, 1);

        do_reset();
        press(KEY_SET); press(KEY_DOWN);
        press(KEY_MODE); press(KEY_DOWN);
        press(KEY_MODE); press(KEY_DOWN);
        press(KEY_SET);
        check_time("preload_max", 23, 59, 59);
        pulse_cnt = 0;
        cycles(9);
        check("pre_roll_pulses", pulse_cnt, 0);
        cycles(1);
        check_time("day_roll", 0, 0, 0);
        check("day_roll_pulses", pulse_cnt, 1);

        press(KEY_SET);
        check("hour_field", edit_field, 1);
        press(KEY_DOWN);
        check("hour_down_wrap", hour, 23);
        press(KEY_UP);
        check("hour_up_wrap", hour, 0);
        check("hour_up_min", minute, 0);
        press(KEY_DOWN);
        check("hour_down_again", hour, 23);
        key_data = KEY_UP; cycles(1);
        key_data = KEY_DOWN; cycles(1);
        key_data = 8'h00; cycles(1);
        check("direct_change", hour, 23);
        press(8'hFF);
        check("bad_code_hour", hour, 23);
        check("bad_code_field", edit_field, 1);

        press(KEY_MODE);
        check("min_field", edit_field, 2);
        check("blink_on_event", blink, 1);
        cycles(BC);
        check("blink_off", blink, 0);
        press(KEY_DOWN);
        check("min_down_wrap", minute, 59);
        check("min_down_hour", hour, 23);
        press(KEY_MODE); press(KEY_MODE);
        check("mode_cycle", edit_field, 1);
        press(KEY_SET);
        check("set_exit", edit_field, 0);

        press(KEY_SET); press(KEY_MODE); press(KEY_MODE);
        check("hold_start", second, 0);
        key_data = KEY_UP;
        cycles(41);
        key_data = 8'h00;
        cycles(1);
        check("hold_repeat", second, 6);

        press(KEY_SET);
        pulse_cnt = 0;
        cycles(8);
        key_data = KEY_SET; cycles(1);
        key_data = 8'h00;   cycles(1);
        check("set_vs_tick_pulses", pulse_cnt, 0);
        check("set_vs_tick_sec", second, 6);
        check("set_vs_tick_field", edit_field, 1);

        @(negedge clk_in);
        #2 rst_in = 1'b1;
        #1;
        check_time("async_rst", 0, 0, 0);
        check("async_rst_field", edit_field, 0);
        check("async_rst_blink", blink, 1);
        check("async_rst_pulse", sec_pulse, 0);
        cycles(2);
        rst_in = 1'b0;
        cycles(15);
        check_time("post_rst", 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Time-of-day keeper and key-driven setting controller for the front-panel clock. Consumes the debounced 8-bit key code from the key debounce stage, turns code changes into press events with auto-repeat on UP/DOWN, and runs an edit state machine that adjusts hour, minute or second. Outside edit mode it counts real time from the system clock. Outputs drive the display formatter directly.

## Interface
- CLK_FREQ, 12_000_000: system clock cycles per second; second prescaler terminal count.
- HOLD_CYC, 6_000_000: cycles an UP/DOWN code must persist before auto-repeat starts (500 ms).
- REPEAT_CYC, 1_200_000: cycles between auto-repeat steps (100 ms).
- BLINK_CYC, 3_000_000: blink half-period in edit mode (250 ms).
- clk_in  input  1  system clock.
- rst_in  input  1  reset, asynchronous, active-high.
- key_data  input  8  debounced key code: 0x07 MODE, 0x0B UP, 0x0D DOWN, 0x0E SET, 0x00 none.
- hour  output  5  0..23.
- minute  output  6  0..59.
- second  output  6  0..59.
- edit_field  output  2  0 run, 1 hour, 2 minute, 3 second.
- blink  output  1  display-enable for the edited field.
- sec_pulse  output  1  one-cycle strobe on each running-time second increment.

## Operation
- Any key_data value other than the four codes and 0x00 is treated as 0x00.
- key_data is registered as key_prev. A press event occurs in a cycle where the decoded code differs from key_prev and is non-zero. A direct change from one code to another is a press of the new code.
- Auto-repeat applies to UP/DOWN only. While the code equals key_prev, a hold counter runs. At HOLD_CYC it emits a repeat event, then emits one every REPEAT_CYC. The counter clears on any code change.
- States are RUN, EDIT_HOUR, EDIT_MIN and EDIT_SEC. edit_field is 0, 1, 2 and 3 respectively.
- In RUN, SET moves to EDIT_HOUR. MODE, UP and DOWN are ignored.
- In any EDIT state, SET returns to RUN.
- In any EDIT state, MODE cycles the field: HOUR to MIN to SEC to HOUR.
- In any EDIT state, UP adds 1 and DOWN subtracts 1 from the selected field, with modular wrap. Hour wraps 23 to 0 and 0 to 23. Minute and second wrap 59 to 0 and 0 to 59. Adjusting a field never carries into neighbouring fields.
- Timekeeping runs in RUN only. The prescaler counts 0..CLK_FREQ-1. At terminal count, second increments and sec_pulse fires. Carries cascade: 59 s rolls minute, 59 min rolls hour, 23:59:59 becomes 00:00:00.
- In EDIT states, the prescaler is held at 0 and time is frozen.
- blink is 1 in RUN. In EDIT it toggles every BLINK_CYC cycles. Each press or repeat event forces blink to 1 and restarts the blink counter.

## Timing
- Reset values: hour, minute and second 0; edit_field 0; sec_pulse 0; blink 1. State RUN; key_prev 0x00; all counters 0.
- Reset asserted mid-edit returns to RUN at 00:00:00 immediately (asynchronous).
- Latency: key_data changes sampled at edge N; the updated field, state and edit_field are visible after edge N+1. Same for repeat events.
- First second after entering RUN (reset release or SET exit) arrives CLK_FREQ cycles later. sec_pulse is coincident with the registered second update.
- SET in RUN in the same cycle as prescaler terminal: the state change wins. No increment and no sec_pulse.
- All counters are sized for their parameter, e.g. 24 bits for CLK_FREQ. No counter exceeds its terminal value.

## Structure
- Package time_set_pkg holds:
  - key code constants KEY_MODE/KEY_UP/KEY_DOWN/KEY_SET/KEY_NONE;
  - state enum;
  - HOUR_MAX=23 and MIN_SEC_MAX=59.
- Sub-module key_repeat implements decode, edge detect and auto-repeat. Its ports are clk_in, rst_in, key_data, HOLD_CYC/REPEAT_CYC parameters, and one-cycle outputs ev_mode, ev_up, ev_down, ev_set.
- The top level holds the FSM, field adders, prescaler and blink counter.

## Test plan
- Reset, then idle with CLK_FREQ reduced to 10: sec_pulse every 10 cycles. Starting from 00:00:59, the next tick gives 00:01:00.
- Preload 23:59:59 through edit, return to RUN: one tick later 00:00:00 with a single sec_pulse.
- SET then UP ×1 from hour 23: hour 0, minute unchanged. DOWN ×1 gives 23. edit_field=1.
- SET, MODE, DOWN at minute 0: minute 59, edit_field=2. MODE twice more gives edit_field=1. SET gives edit_field=0.
- Hold UP in EDIT_SEC with HOLD_CYC=20 and REPEAT_CYC=5 for 41 cycles: second advances by 1+1+4=6 (press, hold at 20, repeats at 25/30/35/40).
- SET coincident with prescaler terminal: no sec_pulse and second unchanged. Also assert rst_in mid-edit: outputs return to reset values asynchronously.
